// File: rtl/uart_pattern_tx.sv
// uart_pattern_tx: autonomous UART source of incrementing bytes with an idle gap between frames.
// Define UART_TX_PARITY_EN to append an even-parity bit after the data bits.
module uart_pattern_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int GAP_BITS = 2,
  parameter logic [DATA_WIDTH-1:0] SEED_RESET = 8'h0A
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  baudTick,
  input  logic                  enable,
  input  logic                  load_seed,
  input  logic [DATA_WIDTH-1:0] seed,
  output logic                  tx,
  output logic                  tx_busy,
  output logic                  byte_sent,
  output logic [DATA_WIDTH-1:0] last_byte,
  output logic [15:0]           sent_count
);
`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, GAP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, GAP} state_t;
`endif
  localparam logic [7:0] LAST_BIT = 8'(DATA_WIDTH - 1);
  localparam logic [7:0] LAST_GAP = 8'(GAP_BITS - 1);
  state_t state_q, state_d;
  logic [3:0] tk_q, tk_d;
  logic [7:0] idx_q, idx_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d, pattern_q, pattern_d, last_q, last_d;
  logic [15:0] cnt_q, cnt_d;
  logic tx_q, tx_d, busy_q, busy_d, sent_q, sent_d;
  logic bnd;
  assign bnd = baudTick && (tk_q == 4'hF);
  always_comb begin
    state_d = state_q;
    tk_d = tk_q;
    idx_d = idx_q;
    shift_d = shift_q;
    pattern_d = pattern_q;
    last_d = last_q;
    cnt_d = cnt_q;
    sent_d = 1'b0;
    tx_d = 1'b1;
    if (state_q != IDLE && baudTick) tk_d = tk_q + 4'd1;
    case (state_q)
      IDLE: begin
        if (load_seed) pattern_d = seed;
        else if (enable) begin
          shift_d = pattern_q;
          tk_d = 4'd0;
          idx_d = 8'd0;
          state_d = START;
        end
      end
      START: begin
        tx_d = 1'b0;
        if (bnd) state_d = DATA;
      end
      DATA: begin
        tx_d = shift_q[0];
        if (bnd) begin
          shift_d = shift_q >> 1;
          idx_d = idx_q + 8'd1;
`ifdef UART_TX_PARITY_EN
          if (idx_q == LAST_BIT) state_d = PARITY;
`else
          if (idx_q == LAST_BIT) state_d = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        tx_d = ^pattern_q;
        if (bnd) state_d = STOP;
      end
`endif
      STOP: begin
        if (bnd) begin
          sent_d = 1'b1;
          last_d = pattern_q;
          pattern_d = pattern_q + DATA_WIDTH'(1);
          cnt_d = cnt_q + 16'(~&cnt_q);
          idx_d = 8'd0;
          state_d = (GAP_BITS == 0) ? IDLE : GAP;
        end
      end
      GAP: begin
        if (bnd) begin
          idx_d = idx_q + 8'd1;
          if (idx_q == LAST_GAP) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // busy rises one edge after leaving IDLE and drops on the edge that re-enters it
    busy_d = (state_q != IDLE) && (state_d != IDLE);
  end
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q <= IDLE;
      tk_q <= 4'd0;
      idx_q <= 8'd0;
      shift_q <= '0;
      pattern_q <= SEED_RESET;
      last_q <= '0;
      cnt_q <= 16'd0;
      tx_q <= 1'b1;
      busy_q <= 1'b0;
      sent_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tk_q <= tk_d;
      idx_q <= idx_d;
      shift_q <= shift_d;
      pattern_q <= pattern_d;
      last_q <= last_d;
      cnt_q <= cnt_d;
      tx_q <= tx_d;
      busy_q <= busy_d;
      sent_q <= sent_d;
    end
  end
  assign tx = tx_q;
  assign tx_busy = busy_q;
  assign byte_sent = sent_q;
  assign last_byte = last_q;
  assign sent_count = cnt_q;
endmodule

// File: tb/tb_uart_pattern_tx.sv
// tb_uart_pattern_tx: directed checks of the UART pattern source with a fast 16x tick (every 4 clk).
module tb_uart_pattern_tx;
  logic clk = 1'b0, rstN = 1'b0, baudTick = 1'b0, enable = 1'b0, load_seed = 1'b0;
  logic [7:0] seed = 8'h00;
  logic tx, tx_busy, byte_sent;
  logic [7:0] last_byte;
  logic [15:0] sent_count;
  int total = 0, bad = 0, ticks = 0, div = 0;
  logic par_seen = 1'b0;

  uart_pattern_tx dut (
    .clk(clk), .rstN(rstN), .baudTick(baudTick), .enable(enable), .load_seed(load_seed),
    .seed(seed), .tx(tx), .tx_busy(tx_busy), .byte_sent(byte_sent), .last_byte(last_byte),
    .sent_count(sent_count)
  );

  always #5 clk = ~clk;
  always @(negedge clk) begin
    div = (div + 1) % 4;
    baudTick = (div == 0);
  end
  always @(posedge clk) if (baudTick) ticks++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    int t0;
    t0 = ticks;
    while (ticks < t0 + n) @(negedge clk);
  endtask

  // which: 0 = tx low, 1 = byte_sent high, 2 = tx_busy low
  task automatic wait_sig(input string tag, input int which, input int limit);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < limit && !ok; i++) begin
      @(negedge clk);
      ok = (which == 0 && tx === 1'b0) || (which == 1 && byte_sent === 1'b1) ||
           (which == 2 && tx_busy === 1'b0);
    end
    chk(tag, ok, 1'b1);
  endtask

  task automatic rx_frame(input string tag, input logic [7:0] exp);
    logic [7:0] d;
    d = 8'h00;
    wait_sig({tag, "_start"}, 0, 4000);
    wait_ticks(8);
    for (int i = 0; i < 8; i++) begin
      wait_ticks(16);
      d[i] = tx;
    end
`ifdef UART_TX_PARITY_EN
    wait_ticks(16);
    par_seen = tx;
`endif
    wait_ticks(16);
    chk({tag, "_stop"}, tx, 1'b1);
    chk({tag, "_data"}, d, exp);
    wait_sig({tag, "_sent"}, 1, 200);
    chk({tag, "_last"}, last_byte, exp);
  endtask

  task automatic gap_check(input string tag);
    int t0;
    t0 = ticks;
    wait_sig({tag, "_end"}, 0, 1000);
    chk(tag, ticks - t0, 32);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstN = 1'b0;
    enable = 1'b0;
    load_seed = 1'b0;
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic quiet;
    int ts;
    repeat (3) @(negedge clk);
    chk("rst_tx_held", tx, 1'b1);
    rstN = 1'b1;
    @(negedge clk);
    chk("rst_tx", tx, 1'b1);
    chk("rst_busy", tx_busy, 1'b0);
    chk("rst_sent", byte_sent, 1'b0);
    chk("rst_last", last_byte, 8'h00);
    chk("rst_count", sent_count, 16'd0);
    // default seed frame
    enable = 1'b1;
    rx_frame("f0a", 8'h0A);
    chk("f0a_count", sent_count, 16'd1);
    @(negedge clk);
    chk("f0a_pulse_width", byte_sent, 1'b0);
    enable = 1'b0;
    wait_sig("f0a_idle", 2, 1000);
    // seed load then wrap-around
    do_reset();
    seed = 8'hFE;
    load_seed = 1'b1;
    @(negedge clk);
    load_seed = 1'b0;
    enable = 1'b1;
    rx_frame("ffe", 8'hFE);
    gap_check("gap1");
    rx_frame("fff", 8'hFF);
    gap_check("gap2");
    rx_frame("f00", 8'h00);
    enable = 1'b0;
    chk("wrap_count", sent_count, 16'd3);
    wait_sig("wrap_idle", 2, 1000);
    // seed and enable together; later seed load outside IDLE ignored
    do_reset();
    seed = 8'h55;
    load_seed = 1'b1;
    enable = 1'b1;
    @(negedge clk);
    load_seed = 1'b0;
    rx_frame("f55", 8'h55);
    seed = 8'h33;
    load_seed = 1'b1;
    @(negedge clk);
    load_seed = 1'b0;
    rx_frame("f56", 8'h56);
    enable = 1'b0;
    wait_sig("f56_idle", 2, 1000);
    // enable dropped during data bit 3
    do_reset();
    enable = 1'b1;
    wait_sig("drop_start", 0, 1000);
    wait_ticks(72);
    enable = 1'b0;
    wait_sig("drop_sent", 1, 2000);
    chk("drop_last", last_byte, 8'h0A);
    ts = ticks;
    wait_sig("drop_idle", 2, 1000);
    chk("drop_gap", ticks - ts, 32);
    quiet = 1'b1;
    repeat (400) begin
      @(negedge clk);
      if (tx !== 1'b1 || tx_busy !== 1'b0) quiet = 1'b0;
    end
    chk("drop_quiet", quiet, 1'b1);
    chk("drop_count", sent_count, 16'd1);
    // asynchronous reset during data bit 5
    do_reset();
    enable = 1'b1;
    wait_sig("ar_start", 0, 1000);
    wait_ticks(104);
    chk("ar_bit5_low", tx, 1'b0);
    rstN = 1'b0;
    #1;
    chk("ar_tx", tx, 1'b1);
    chk("ar_busy", tx_busy, 1'b0);
    chk("ar_count", sent_count, 16'd0);
    @(negedge clk);
    rstN = 1'b1;
    rx_frame("ar_f0a", 8'h0A);
    chk("ar_count2", sent_count, 16'd1);
    enable = 1'b0;
    wait_sig("ar_idle", 2, 1000);
`ifdef UART_TX_PARITY_EN
    do_reset();
    seed = 8'h07;
    load_seed = 1'b1;
    @(negedge clk);
    load_seed = 1'b0;
    enable = 1'b1;
    wait_sig("p07_fall", 0, 1000);
    ts = ticks;
    rx_frame("p07", 8'h07);
    chk("p07_par", par_seen, 1'b1);
    chk("p07_len", (ticks - ts == 175) || (ticks - ts == 176), 1'b1);
    enable = 1'b0;
    wait_sig("p07_idle", 2, 1000);
    seed = 8'h03;
    load_seed = 1'b1;
    @(negedge clk);
    load_seed = 1'b0;
    enable = 1'b1;
    wait_sig("p03_fall", 0, 1000);
    ts = ticks;
    rx_frame("p03", 8'h03);
    chk("p03_par", par_seen, 1'b0);
    chk("p03_len", (ticks - ts == 175) || (ticks - ts == 176), 1'b1);
    enable = 1'b0;
    wait_sig("p03_idle", 2, 1000);
    force dut.cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.cnt_q;
    enable = 1'b1;
    rx_frame("sat", 8'h04);
    chk("sat_count", sent_count, 16'hFFFF);
    enable = 1'b0;
    wait_sig("sat_idle", 2, 1000);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
